siphash_round_sched: RTL

SIPHASH_ROUND_SCHED -- requirements
Module: siphash_round_sched

---
 rtl/siphash_pkg.sv | 27 ++
 rtl/siphash_round.sv | 43 ++++
 rtl/siphash_round_sched.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/siphash_pkg.sv
// Shared definitions for the SipHash round scheduler: IV constants, the
// finalization constant, the FSM state enum, the 64-bit word type and a
// rotate-left helper.
package siphash_pkg;

  typedef logic [63:0] word_t;

  localparam word_t IvV0   = 64'h736f6d6570736575;
  localparam word_t IvV1   = 64'h646f72616e646f6d;
  localparam word_t IvV2   = 64'h6c7967656e657261;
  localparam word_t IvV3   = 64'h7465646279746573;
  localparam word_t FinXor = 64'h00000000000000ff;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StWaitWord,
    StComp,
    StFinal,
    StDone
  } state_e;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (64 - n));
  endfunction

endpackage

// File: rtl/siphash_round.sv
// One combinational SipRound.
// Ports: v0_i..v3_i - state words in; v0_o..v3_o - state words after the round.
module siphash_round
  import siphash_pkg::*;
(
  input  word_t v0_i,
  input  word_t v1_i,
  input  word_t v2_i,
  input  word_t v3_i,
  output word_t v0_o,
  output word_t v1_o,
  output word_t v2_o,
  output word_t v3_o
);

  word_t a0, a1, a2, a3;

  always_comb begin
    a0 = v0_i;
    a1 = v1_i;
    a2 = v2_i;
    a3 = v3_i;
    a0 = a0 + a1;
    a1 = rotl(a1, 13);
    a1 = a1 ^ a0;
    a0 = rotl(a0, 32);
    a2 = a2 + a3;
    a3 = rotl(a3, 16);
    a3 = a3 ^ a2;
    a0 = a0 + a3;
    a3 = rotl(a3, 21);
    a3 = a3 ^ a0;
    a2 = a2 + a1;
    a1 = rotl(a1, 17);
    a1 = a1 ^ a2;
    a2 = rotl(a2, 32);
    v0_o = a0;
    v1_o = a1;
    v2_o = a2;
    v3_o = a3;
  end

endmodule

// File: rtl/siphash_round_sched.sv
// SipHash-c-d scheduler: one shared SipRound, message words streamed in.
// Ports: ACLK/ARESETN clock and async active-low reset; start/key/msg_len
// request a hash; s_msg_* is the 64-bit little-endian word stream; busy marks
// an active hash; hash/hash_valid/hash_ready return the result.
// Optional: define SIPHASH_PERF_CNT_EN to add perf_cycles (start-accept to
// hash_valid rise, saturating).
module siphash_round_sched
  import siphash_pkg::*;
#(
  parameter int unsigned C_ROUNDS = 2,
  parameter int unsigned D_ROUNDS = 4
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          start,
  input  logic [127:0]  key,
  input  logic [31:0]   msg_len,
  input  logic [63:0]   s_msg_tdata,
  input  logic          s_msg_tvalid,
  output logic          s_msg_tready,
  output logic          busy,
  output logic [63:0]   hash,
  output logic          hash_valid,
  input  logic          hash_ready
`ifdef SIPHASH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  state_e        state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [31:0]   len_q, len_d;
  logic [31:0]   rnd_q, rnd_d;
  logic [31:0]   blk_q, blk_d;
  word_t         v0_q, v1_q, v2_q, v3_q, v0_d, v1_d, v2_d, v3_d;
  word_t         m_q, m_d;
  word_t         hash_q, hash_d;
  logic          hash_valid_q, hash_valid_d;

  word_t         rin0, rin1, rin2, rin3, rout0, rout1, rout2, rout3;
  word_t         m_word, m_pad, m_cur, tail_mask;
  logic [31:0]   last_idx;
  logic          last_blk, blk_end;

  siphash_round u_round (
    .v0_i (rin0),
    .v1_i (rin1),
    .v2_i (rin2),
    .v3_i (rin3),
    .v0_o (rout0),
    .v1_o (rout1),
    .v2_o (rout2),
    .v3_o (rout3)
  );

  assign last_idx  = len_q >> 3;
  assign last_blk  = (blk_q == last_idx);
  assign m_pad     = {len_q[7:0], 56'h0};
  assign tail_mask = (64'h1 << {len_q[2:0], 3'b000}) - 64'h1;
  assign m_word    = last_blk ? (m_pad | (s_msg_tdata & tail_mask)) : s_msg_tdata;
  // The word-accept cycle already runs the block's first round.
  assign m_cur     = (state_q == StWaitWord) ? m_word : m_q;

  always_comb begin
    rin0 = v0_q;
    rin1 = v1_q;
    rin2 = v2_q;
    rin3 = v3_q;
    if (state_q == StWaitWord) begin
      rin3 = v3_q ^ m_word;
    end else if (state_q == StComp && rnd_q == 32'd0) begin
      rin3 = v3_q ^ m_q;
    end else if (state_q == StFinal && rnd_q == 32'd0) begin
      rin2 = v2_q ^ FinXor;
    end
  end

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    len_d        = len_q;
    rnd_d        = rnd_q;
    blk_d        = blk_q;
    v0_d         = v0_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    v3_d         = v3_q;
    m_d          = m_q;
    hash_d       = hash_q;
    hash_valid_d = hash_valid_q;
    blk_end      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d   = key;
          len_d   = msg_len;
          state_d = StInit;
        end
      end
      StInit: begin
        v0_d  = key_q[63:0]   ^ IvV0;
        v1_d  = key_q[127:64] ^ IvV1;
        v2_d  = key_q[63:0]   ^ IvV2;
        v3_d  = key_q[127:64] ^ IvV3;
        blk_d = 32'd0;
        rnd_d = 32'd0;
        // Empty message: the only block is pure padding, nothing to fetch.
        if (len_q == 32'd0) begin
          m_d     = m_pad;
          state_d = StComp;
        end else begin
          state_d = StWaitWord;
        end
      end
      StWaitWord: begin
        if (s_msg_tvalid) begin
          m_d  = m_word;
          v0_d = rout0;
          v1_d = rout1;
          v2_d = rout2;
          v3_d = rout3;
          rnd_d = 32'd1;
          if (C_ROUNDS == 1) blk_end = 1'b1;
          else state_d = StComp;
        end
      end
      StComp: begin
        v0_d  = rout0;
        v1_d  = rout1;
        v2_d  = rout2;
        v3_d  = rout3;
        rnd_d = rnd_q + 32'd1;
        if (rnd_q + 32'd1 == C_ROUNDS) blk_end = 1'b1;
      end
      StFinal: begin
        v0_d  = rout0;
        v1_d  = rout1;
        v2_d  = rout2;
        v3_d  = rout3;
        rnd_d = rnd_q + 32'd1;
        if (rnd_q + 32'd1 == D_ROUNDS) state_d = StDone;
      end
      StDone: begin
        if (!hash_valid_q) begin
          hash_d       = v0_q ^ v1_q ^ v2_q ^ v3_q;
          hash_valid_d = 1'b1;
        end else if (hash_ready) begin
          hash_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (blk_end) begin
      v0_d  = rout0 ^ m_cur;
      rnd_d = 32'd0;
      if (last_blk) begin
        state_d = StFinal;
      end else begin
        blk_d = blk_q + 32'd1;
        if (blk_q + 32'd1 == last_idx && len_q[2:0] == 3'd0) begin
          m_d     = m_pad;
          state_d = StComp;
        end else begin
          state_d = StWaitWord;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= StIdle;
      key_q        <= '0;
      len_q        <= '0;
      rnd_q        <= '0;
      blk_q        <= '0;
      v0_q         <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      v3_q         <= '0;
      m_q          <= '0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      len_q        <= len_d;
      rnd_q        <= rnd_d;
      blk_q        <= blk_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      m_q          <= m_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign s_msg_tready = (state_q == StWaitWord);
  assign hash         = hash_q;
  assign hash_valid   = hash_valid_q;

`ifdef SIPHASH_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d, perf_q, perf_d;

  always_comb begin
    cyc_d  = cyc_q;
    perf_d = perf_q;
    if (state_q == StIdle && start) begin
      cyc_d = 32'd1;
    end else if (busy && !hash_valid_q && cyc_q != 32'hffff_ffff) begin
      cyc_d = cyc_q + 32'd1;
    end
    if (state_q == StDone && !hash_valid_q) perf_d = cyc_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cyc_q  <= '0;
      perf_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
